// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: IMEM with load port, reset stretcher, fetch PC, prefetch queue, F/D register.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
module fetch_prefetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter int IMEM_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int RST_STRETCH = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [XLEN-1:0]         imem_din,
    input  logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_web,
    input  logic                    stallD,
    input  logic                    flushD,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [XLEN-1:0]         instrD,
    output logic [XLEN-1:0]         PCD,
    output logic [XLEN-1:0]         PCp4D,
    output logic                    validD,
    output logic                    core_rst_n,
    output logic [$clog2(DEPTH):0]  q_level
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]         perf_fetch_cnt,
    output logic [XLEN-1:0]         perf_bubble_cnt
`endif
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam int QW = $clog2(DEPTH);
    localparam int LW = QW + 1;
    localparam int SW = $clog2(RST_STRETCH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] imem [IMEM_WORDS];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc [DEPTH];
    logic [SW-1:0]   stretch_cnt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] rd_pc;
    logic            rd_valid;
    logic            rd_epoch;
    logic            epoch;
    logic [QW-1:0]   wr_ptr;
    logic [QW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            fetch_en;
    logic            q_empty;
    logic            push;
    logic            pop;
    logic            issue;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{imem_addr[XLEN-1:AW+2], imem_addr[1:0]};
    assign fetch_en = core_rst_n && imem_web;
    assign q_empty  = (count == '0);
    assign push     = fetch_en && !redirect_valid && rd_valid && (rd_epoch == epoch);
    assign pop      = fetch_en && !redirect_valid && !flushD && !stallD && !q_empty;
    // Counting the read already in flight keeps the queue from ever exceeding DEPTH.
    assign issue    = fetch_en && !redirect_valid &&
                      ((int'(count) + int'(rd_valid) - int'(pop)) < DEPTH);
    assign q_level  = count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stretch_cnt <= '0;
            core_rst_n  <= 1'b0;
        end else if (!core_rst_n) begin
            if (stretch_cnt == SW'(RST_STRETCH - 1))
                core_rst_n <= 1'b1;
            stretch_cnt <= stretch_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!imem_web)
            imem[imem_addr[AW+1:2]] <= imem_din;
        if (issue) begin
            rd_data <= imem[pc[AW+1:2]];
            rd_pc   <= pc;
        end
        if (push) begin
            q_instr[wr_ptr] <= rd_data;
            q_pc[wr_ptr]    <= rd_pc;
        end
    end

    // The epoch tag makes any read returning across a redirect land as stale.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= RESET_PC;
            rd_valid <= 1'b0;
            rd_epoch <= 1'b0;
            epoch    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (!fetch_en) begin
            pc       <= RESET_PC;
            rd_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            rd_valid <= 1'b0;
            epoch    <= ~epoch;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                pc       <= pc + XLEN'(4);
                rd_epoch <= epoch;
            end
            if (push)
                wr_ptr <= wr_ptr + QW'(1);
            if (pop)
                rd_ptr <= rd_ptr + QW'(1);
            count <= count + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instrD <= NOP;
            PCD    <= '0;
            PCp4D  <= '0;
            validD <= 1'b0;
        end else if (!fetch_en || redirect_valid || flushD) begin
            instrD <= NOP;
            validD <= 1'b0;
        end else if (!stallD) begin
            if (!q_empty) begin
                instrD <= q_instr[rd_ptr];
                PCD    <= q_pc[rd_ptr];
                PCp4D  <= q_pc[rd_ptr] + XLEN'(4);
                validD <= 1'b1;
            end else begin
                instrD <= NOP;
                validD <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic bubble;
    assign bubble = fetch_en && !redirect_valid && !flushD && !stallD && q_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (pop && !(&perf_fetch_cnt))
                perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
            if (bubble && !(&perf_bubble_cnt))
                perf_bubble_cnt <= perf_bubble_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed scenarios plus a randomized
// stall/flush/redirect run scored against an in-order instruction-stream model.
module tb_fetch_prefetch_unit;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int IMEM_WORDS = 256;
    localparam int RST_STRETCH = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] imem_din;
    logic [31:0] imem_addr;
    logic        imem_web;
    logic        stallD;
    logic        flushD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic [31:0] PCp4D;
    logic        validD;
    logic        core_rst_n;
    logic [2:0]  q_level;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .IMEM_WORDS(IMEM_WORDS),
        .RESET_PC(RESET_PC), .RST_STRETCH(RST_STRETCH)
    ) dut (
        .clk(clk), .rstn(rstn), .imem_din(imem_din), .imem_addr(imem_addr),
        .imem_web(imem_web), .stallD(stallD), .flushD(flushD),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instrD(instrD), .PCD(PCD), .PCp4D(PCp4D), .validD(validD),
        .core_rst_n(core_rst_n), .q_level(q_level)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [IMEM_WORDS];
    logic [31:0] exp_pc;

    function automatic logic [31:0] ref_instr(input logic [31:0] pc);
        return mem[pc[9:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; imem_web = 1'b1; imem_din = '0; imem_addr = '0;
        stallD = 1'b0; flushD = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        checks++; if (instrD !== NOP) begin errors++; $display("[TB] FAIL reset_instrD: got %h want %h", instrD, NOP); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("[TB] FAIL reset_PCD: got %h want 0", PCD); end
        checks++; if (PCp4D !== 32'h0) begin errors++; $display("[TB] FAIL reset_PCp4D: got %h want 0", PCp4D); end
        checks++; if (validD !== 1'b0) begin errors++; $display("[TB] FAIL reset_validD: got %b want 0", validD); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
        checks++; if (q_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_q_level: got %0d want 0", q_level); end
    endtask

    task automatic test_reset_stretch();
        logic want;
        rstn = 1'b1;
        for (int i = 1; i <= RST_STRETCH; i++) begin
            tick();
            want = (i == RST_STRETCH);
            checks++;
            if (core_rst_n !== want) begin
                errors++; $display("[TB] FAIL stretch_edge%0d: got %b want %b", i, core_rst_n, want);
            end
        end
    endtask

    task automatic test_program_load();
        logic [31:0] plan [4];
        logic [31:0] a;
        logic [31:0] d;
        plan[0] = 32'h0050_0093; plan[1] = 32'h00A0_0113;
        plan[2] = 32'h0020_81B3; plan[3] = 32'h0000_0013;
        for (int w = 0; w < IMEM_WORDS; w++) begin
            d = (w < 4) ? plan[w] : $urandom;
            mem[w] = d;
            a = $urandom;
            a[9:2] = w[7:0];
            if (w < 4) a = 32'(w * 4);
            imem_web = 1'b0; imem_din = d; imem_addr = a;
            tick();
            if (w == 0) begin
                checks++;
                if (validD !== 1'b0 || q_level !== 3'd0) begin
                    errors++; $display("[TB] FAIL load_idle: validD=%b q_level=%0d want 0/0", validD, q_level);
                end
            end
        end
        imem_web = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (validD !== 1'b0) begin errors++; $display("[TB] FAIL load_latency_e%0d: validD=%b want 0", e, validD); end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== 32'(4 * i) || PCp4D !== 32'(4 * i + 4) || instrD !== plan[i]) begin
                errors++;
                $display("[TB] FAIL load_stream%0d: v=%b pc=%h p4=%h ins=%h want 1/%h/%h/%h",
                         i, validD, PCD, PCp4D, instrD, 32'(4 * i), 32'(4 * i + 4), plan[i]);
            end
        end
        exp_pc = 32'd16;
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        held_pc = exp_pc - 32'd4;
        stallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== held_pc || instrD !== ref_instr(held_pc) || q_level > 3'(DEPTH)) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: v=%b pc=%h ins=%h lvl=%0d want 1/%h/%h/<=%0d",
                         i, validD, PCD, instrD, q_level, held_pc, ref_instr(held_pc), DEPTH);
            end
        end
        checks++;
        if (q_level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL stall_full: q_level=%0d want %0d", q_level, DEPTH); end
        stallD = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== exp_pc || instrD !== ref_instr(exp_pc) || PCp4D !== exp_pc + 32'd4) begin
                errors++;
                $display("[TB] FAIL stall_resume%0d: v=%b pc=%h ins=%h want 1/%h/%h",
                         i, validD, PCD, instrD, exp_pc, ref_instr(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect_full();
        int n;
        stallD = 1'b1;
        n = 0;
        while (q_level !== 3'(DEPTH) && n < 10) begin tick(); n++; end
        checks++;
        if (q_level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL redir_fill: q_level=%0d want %0d", q_level, DEPTH); end
        stallD = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("[TB] FAIL redir_bubble0: v=%b ins=%h want 0/%h", validD, instrD, NOP); end
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (validD !== 1'b0) begin errors++; $display("[TB] FAIL redir_bubble%0d: v=%b want 0", e, validD); end
        end
        exp_pc = 32'h40;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== exp_pc || instrD !== ref_instr(exp_pc)) begin
                errors++;
                $display("[TB] FAIL redir_stream%0d: v=%b pc=%h ins=%h want 1/%h/%h",
                         i, validD, PCD, instrD, exp_pc, ref_instr(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_flush();
        flushD = 1'b1;
        tick();
        flushD = 1'b0;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("[TB] FAIL flush_bubble: v=%b ins=%h want 0/%h", validD, instrD, NOP); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== exp_pc || instrD !== ref_instr(exp_pc)) begin
                errors++;
                $display("[TB] FAIL flush_next%0d: v=%b pc=%h ins=%h want 1/%h/%h",
                         i, validD, PCD, instrD, exp_pc, ref_instr(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect_stall();
        int n;
        stallD = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        stallD = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP) begin errors++; $display("[TB] FAIL redir_stall_bubble: v=%b ins=%h want 0/%h", validD, instrD, NOP); end
        n = 0;
        do begin tick(); n++; end while (validD !== 1'b1 && n < 8);
        checks++;
        if (validD !== 1'b1 || n != 3 || PCD !== 32'h80 || instrD !== ref_instr(32'h80)) begin
            errors++;
            $display("[TB] FAIL redir_stall_first: v=%b edges=%0d pc=%h ins=%h want 1/3/00000080/%h",
                     validD, n, PCD, instrD, ref_instr(32'h80));
        end
        exp_pc = 32'h84;
    endtask

    task automatic test_async_reset();
        int n;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP || PCD !== 32'h0 || PCp4D !== 32'h0 || q_level !== 3'd0 || core_rst_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: v=%b ins=%h pc=%h p4=%h lvl=%0d crst=%b want 0/%h/0/0/0/0",
                     validD, instrD, PCD, PCp4D, q_level, core_rst_n, NOP);
        end
        tick(); tick();
        rstn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (core_rst_n !== 1'b1 && n < 10);
        checks++;
        if (n != RST_STRETCH || core_rst_n !== 1'b1) begin
            errors++; $display("[TB] FAIL async_stretch: edges=%0d crst=%b want %0d/1", n, core_rst_n, RST_STRETCH);
        end
        n = 0;
        do begin tick(); n++; end while (validD !== 1'b1 && n < 10);
        checks++;
        if (validD !== 1'b1 || n != 3 || PCD !== RESET_PC || instrD !== ref_instr(RESET_PC) || PCp4D !== RESET_PC + 32'd4) begin
            errors++;
            $display("[TB] FAIL async_restart: v=%b edges=%0d pc=%h ins=%h want 1/3/%h/%h",
                     validD, n, PCD, instrD, RESET_PC, ref_instr(RESET_PC));
        end
        exp_pc = RESET_PC + 32'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (validD !== 1'b1 || PCD !== exp_pc || instrD !== ref_instr(exp_pc)) begin
                errors++;
                $display("[TB] FAIL async_stream%0d: v=%b pc=%h ins=%h want 1/%h/%h",
                         i, validD, PCD, instrD, exp_pc, ref_instr(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_random();
        logic        last_valid;
        logic [31:0] last_pc;
        logic [31:0] tgt;
        int          r;
        int          delivered;
        last_valid = 1'b1;
        last_pc    = exp_pc - 32'd4;
        delivered  = 0;
        for (int c = 0; c < 500; c++) begin
            r   = $urandom_range(0, 99);
            tgt = 32'($urandom_range(0, 255)) << 2;
            redirect_valid = (r < 3);
            flushD         = (r >= 3 && r < 12);
            stallD         = ($urandom_range(0, 99) < 30);
            redirect_pc    = tgt;
            tick();
            checks++;
            if (q_level > 3'(DEPTH)) begin errors++; $display("[TB] FAIL rnd_level%0d: q_level=%0d want <=%0d", c, q_level, DEPTH); end
            if (redirect_valid || flushD) begin
                checks++;
                if (validD !== 1'b0 || instrD !== NOP) begin
                    errors++; $display("[TB] FAIL rnd_bubble%0d: v=%b ins=%h want 0/%h", c, validD, instrD, NOP);
                end
                last_valid = 1'b0;
                if (redirect_valid) exp_pc = tgt;
            end else if (stallD) begin
                checks++;
                if (validD !== last_valid || (last_valid ? (PCD !== last_pc || instrD !== ref_instr(last_pc)) : (instrD !== NOP))) begin
                    errors++;
                    $display("[TB] FAIL rnd_hold%0d: v=%b pc=%h ins=%h want %b/%h", c, validD, PCD, instrD, last_valid, last_pc);
                end
            end else if (validD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || instrD !== ref_instr(exp_pc) || PCp4D !== exp_pc + 32'd4) begin
                    errors++;
                    $display("[TB] FAIL rnd_stream%0d: pc=%h ins=%h p4=%h want %h/%h/%h",
                             c, PCD, instrD, PCp4D, exp_pc, ref_instr(exp_pc), exp_pc + 32'd4);
                end
                last_valid = 1'b1;
                last_pc    = exp_pc;
                exp_pc    += 32'd4;
                delivered++;
            end else begin
                checks++;
                if (instrD !== NOP) begin errors++; $display("[TB] FAIL rnd_empty%0d: ins=%h want %h", c, instrD, NOP); end
                last_valid = 1'b0;
            end
        end
        redirect_valid = 1'b0; flushD = 1'b0; stallD = 1'b0;
        checks++;
        if (delivered < 100) begin errors++; $display("[TB] FAIL rnd_throughput: delivered=%0d want >=100", delivered); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_stretch();
        test_program_load();
        test_stall();
        test_redirect_full();
        test_flush();
        test_redirect_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
